// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine holding the HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
// Signed operations run on magnitudes; signs are re-applied on the final step.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- when defined, a multiply leaves
// RUN as soon as the remaining unshifted multiplier bits are all zero.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   logic               isDiv_q, isDiv_d;
   logic               negRes_q, negRes_d;
   logic               negRem_q, negRem_d;
   logic               divZero_q, divZero_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   dvsr_q, dvsr_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               signedOp;
   logic               aNeg;
   logic               bNeg;
   logic [WIDTH-1:0]   aMag;
   logic [WIDTH-1:0]   bMag;
   logic [WIDTH:0]     trial;
   logic               qBit;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   resHi;
   logic [WIDTH-1:0]   resLo;
   logic               lastStep;

   // State and datapath registers; reset abandons any operation and clears HI/LO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         isDiv_q   <= 1'b0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         divZero_q <= 1'b0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvsr_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         isDiv_q   <= isDiv_d;
         negRes_q  <= negRes_d;
         negRem_q  <= negRem_d;
         divZero_q <= divZero_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvsr_q    <= dvsr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Next-state logic: operand capture in IDLE, one arithmetic step per RUN cycle,
   // and the sign-corrected HI/LO load on the final step.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      isDiv_d   = isDiv_q;
      negRes_d  = negRes_q;
      negRem_d  = negRem_q;
      divZero_d = divZero_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      signedOp  = ~op[0];
      aNeg      = signedOp & a[WIDTH-1];
      bNeg      = signedOp & b[WIDTH-1];
      aMag      = aNeg ? -a : a;
      bMag      = bNeg ? -b : b;
      trial     = '0;
      qBit      = 1'b0;
      product   = '0;
      resHi     = '0;
      resLo     = '0;
      lastStep  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               isDiv_d   = op[1];
               negRes_d  = aNeg ^ bNeg;
               negRem_d  = aNeg;
               divZero_d = (b == '0);
               acc_d     = '0;
               mcand_d   = {{WIDTH{1'b0}}, aMag};
               mplier_d  = bMag;
               rem_d     = '0;
               quo_d     = aMag;
               dvsr_d    = bMag;
               count_d   = '0;
               state_d   = RUN;
            end else begin
               if (mthi) begin
                  hi_d = a;
               end
               if (mtlo) begin
                  lo_d = a;
               end
            end
         end

         RUN: begin
            count_d  = count_q + CW'(1);
            lastStep = (count_q == LAST);
            if (!isDiv_q) begin
               if (mplier_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
`ifdef MULDIV_EARLY_OUT_EN
               if (mplier_d == '0) begin
                  lastStep = 1'b1;
               end
`endif
               product = negRes_q ? -acc_d : acc_d;
               resHi   = product[2*WIDTH-1:WIDTH];
               resLo   = product[WIDTH-1:0];
            end else begin
               trial = {rem_q, quo_q[WIDTH-1]};
               if (trial >= {1'b0, dvsr_q}) begin
                  trial = trial - {1'b0, dvsr_q};
                  qBit  = 1'b1;
               end
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], qBit};
               resLo = divZero_q ? '1 : (negRes_q ? -quo_d : quo_d);
               resHi = negRem_q ? -rem_d : rem_d;
            end
            if (lastStep) begin
               hi_d    = resHi;
               lo_d    = resLo;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status and architectural register outputs.
   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
      hi   = hi_q;
      lo   = lo_q;
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against a
// behavioural arithmetic/latency model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        mthi;
   logic        mtlo;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int errors   = 0;
   int doneSeen = 0;
   bit checkEn  = 1'b0;

   int          mRemain = 0;
   bit          mDone   = 1'b0;
   logic [31:0] mHi     = '0;
   logic [31:0] mLo     = '0;
   logic [31:0] pHi;
   logic [31:0] pLo;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit s, input logic [1:0] o, input logic [31:0] x,
                                input logic [31:0] y, input bit h, input bit l);
      start = s;
      op    = o;
      a     = x;
      b     = y;
      mthi  = h;
      mtlo  = l;
   endtask

   // Architectural result of one operation, from plain integer arithmetic.
   function automatic void modelResult(input logic [1:0] o, input logic [31:0] x,
                                       input logic [31:0] y, output logic [31:0] rHi,
                                       output logic [31:0] rLo);
      longint          sx;
      longint          sy;
      longint          q;
      longint          m;
      logic [63:0]     p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p  = '0;
      q  = 0;
      m  = 0;
      rHi = '0;
      rLo = '0;
      case (o)
         2'b00: begin
            p   = sx * sy;
            rHi = p[63:32];
            rLo = p[31:0];
         end
         2'b01: begin
            p   = {32'b0, x} * {32'b0, y};
            rHi = p[63:32];
            rLo = p[31:0];
         end
         default: begin
            if (y == 32'b0) begin
               rLo = 32'hFFFFFFFF;
               rHi = x;
            end else if (o == 2'b10) begin
               q   = sx / sy;
               m   = sx % sy;
               rLo = q[31:0];
               rHi = m[31:0];
            end else begin
               rLo = x / y;
               rHi = x % y;
            end
         end
      endcase
   endfunction

   // Number of RUN cycles an operation occupies.
   function automatic int runLen(input logic [1:0] o, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
      logic [31:0] mag;
      int          n;
      if (o[1]) return 32;
      mag = (o == 2'b00 && y[31]) ? -y : y;
      n   = 1;
      for (int i = 0; i < 32; i++) begin
         if (mag[i]) n = i + 1;
      end
      return n;
`else
      return 32;
`endif
   endfunction

   // Reference model: tracks what busy/done/hi/lo must be after every edge.
   always @(posedge clk) begin
      if (rst) begin
         mRemain = 0;
         mDone   = 1'b0;
         mHi     = '0;
         mLo     = '0;
      end else if (mDone) begin
         mDone = 1'b0;
      end else if (mRemain > 0) begin
         mRemain--;
         if (mRemain == 0) begin
            mDone = 1'b1;
            mHi   = pHi;
            mLo   = pLo;
         end
      end else if (start) begin
         modelResult(op, a, b, pHi, pLo);
         mRemain = runLen(op, b);
      end else begin
         if (mthi) mHi = a;
         if (mtlo) mLo = a;
      end
   end

   // Per-cycle comparison of the DUT against the model, away from the active edge.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("busy", 64'(busy), 64'((mRemain > 0) || mDone));
         checkOutput("done", 64'(done), 64'(mDone));
         checkOutput("hi", 64'(hi), 64'(mHi));
         checkOutput("lo", 64'(lo), 64'(mLo));
         if (done === 1'b1) doneSeen++;
      end
   end

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h00000000;
         1:       return 32'hFFFFFFFF;
         2:       return 32'h80000000;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Issue one operation from IDLE and wait (bounded) for done; lat counts the
   // sampling edge as edge 1.
   task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit noise, input int injectAt, output int lat);
      @(negedge clk);
      applyStimulus(1'b1, o, x, y, noise ? 1'($urandom_range(0, 1)) : 1'b0,
                    noise ? 1'($urandom_range(0, 1)) : 1'b0);
      @(negedge clk);
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         if (lat == injectAt)
            applyStimulus(1'b1, 2'b10, 32'd9, 32'd0, 1'b0, 1'b1);
         else if (noise)
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                          $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else
            applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
         @(negedge clk);
         lat++;
      end
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
      if (done !== 1'b1) checkOutput("done_timeout", 64'(done), 64'd1);
   endtask

   // Global watchdog so the run always terminates.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence followed by randomized operations.
   initial begin
      int lat;
      int d0;
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;

      rst = 1'b1;
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkEn = 1'b1;
      checkOutput("reset_hi", 64'(hi), 64'd0);
      checkOutput("reset_lo", 64'(lo), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      rst = 1'b0;

      d0 = doneSeen;
      runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, lat);
      checkOutput("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
      checkOutput("multu_max_lo", 64'(lo), 64'h00000001);
      checkOutput("multu_max_latency", 64'(lat), 64'd33);
      repeat (3) @(negedge clk);
      checkOutput("multu_max_done_pulses", 64'(doneSeen - d0), 64'd1);

      runOp(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, -1, lat);
      checkOutput("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
      checkOutput("mult_neg_lo", 64'(lo), 64'hFFFFFFEB);

      runOp(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, -1, lat);
      checkOutput("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
      checkOutput("div_neg_hi", 64'(hi), 64'hFFFFFFFF);
      checkOutput("div_latency", 64'(lat), 64'd33);

      runOp(2'b11, 32'd7, 32'd0, 1'b0, -1, lat);
      checkOutput("divu_zero_lo", 64'(lo), 64'hFFFFFFFF);
      checkOutput("divu_zero_hi", 64'(hi), 64'h00000007);

      runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1, lat);
      checkOutput("div_wrap_lo", 64'(lo), 64'h80000000);
      checkOutput("div_wrap_hi", 64'(hi), 64'h00000000);

      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 32'h12345678, 32'd0, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("mthi_hi", 64'(hi), 64'h12345678);

      runOp(2'b01, 32'd2, 32'd3, 1'b0, 5, lat);
      checkOutput("ignored_start_hi", 64'(hi), 64'd0);
      checkOutput("ignored_start_lo", 64'(lo), 64'd6);

      @(negedge clk);
      applyStimulus(1'b1, 2'b01, 32'd5, 32'd7, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_hi", 64'(hi), 64'd0);
      checkOutput("abort_lo", 64'(lo), 64'd0);
      d0 = doneSeen;
      repeat (40) @(negedge clk);
      checkOutput("abort_no_done", 64'(doneSeen - d0), 64'd0);

`ifdef MULDIV_EARLY_OUT_EN
      runOp(2'b01, 32'd100, 32'd5, 1'b0, -1, lat);
      checkOutput("early_lo", 64'(lo), 64'd500);
      checkOutput("early_latency", 64'(lat), 64'd4);
      runOp(2'b01, 32'h00001234, 32'd0, 1'b0, -1, lat);
      checkOutput("early_zero_lo", 64'(lo), 64'd0);
      checkOutput("early_zero_hi", 64'(hi), 64'd0);
      checkOutput("early_zero_latency", 64'(lat), 64'd2);
`endif

      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         applyStimulus(1'b0, 2'b00, $urandom, 32'd0, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
         ro = 2'($urandom_range(0, 3));
         ra = pickOperand();
         rb = pickOperand();
         runOp(ro, ra, rb, 1'b1, -1, lat);
         checkOutput("random_latency", 64'(lat), 64'(runLen(ro, rb) + 1));
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
